// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshake and FIFO write-side bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128
);
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        i_req_last;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic                      i_fifo_alm_full;
    logic                      o_fifo_wren;
    logic [DATA_W-1:0]         o_fifo_wrdata;
    logic [NUM_REQ-1:0]        o_grant;
    logic                      o_busy;
    logic [31:0]               o_wr_count;

    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_fifo_alm_full,
        output o_req_ready, o_fifo_wren, o_fifo_wrdata, o_grant, o_busy, o_wr_count
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_fifo_alm_full,
        input  o_req_ready, o_fifo_wren, o_fifo_wrdata, o_grant, o_busy, o_wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 4
) (
    input logic                clk,
    input logic                rstn,
    fifo_wr_arbiter_if.master  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d, pick;
    logic [7:0]         burst_q, burst_d;
    logic               wren_q, wren_d;
    logic [DATA_W-1:0]  wrdata_q, wrdata_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ready;
    logic               found, accept;

    // Scan from the farthest offset down so the nearest valid after last_q wins
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.i_req_valid[(int'(last_q) + i) % NUM_REQ]) begin
                pick  = IW'((int'(last_q) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign ready  = (state_q == GRANT && !bus.i_fifo_alm_full) ? grant_q : '0;
    assign accept = |(bus.i_req_valid & ready);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        burst_d  = burst_q;
        wren_d   = 1'b0;
        wrdata_d = wrdata_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                grant_d = NUM_REQ'(1) << pick;
                last_d  = pick;
                burst_d = 8'd0;
            end
        end else if (accept) begin
            wren_d   = 1'b1;
            wrdata_d = bus.i_req_data[int'(last_q)*DATA_W +: DATA_W];
            burst_d  = burst_q + 8'd1;
            cnt_d    = cnt_q + 32'd1;
            if (bus.i_req_last[last_q] || burst_d == 8'(MAX_BURST)) begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else if (!bus.i_req_valid[last_q] && !bus.i_fifo_alm_full) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            burst_q  <= 8'd0;
            wren_q   <= 1'b0;
            wrdata_q <= '0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_req_ready   = ready;
    assign bus.o_fifo_wren   = wren_q;
    assign bus.o_fifo_wrdata = wrdata_q;
    assign bus.o_grant       = grant_q;
    assign bus.o_busy        = (state_q == GRANT);
    assign bus.o_wr_count    = cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with queue-based scoreboard for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 128;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    beat_t        pq[N][$];
    logic [W-1:0] exp_q[$];
    logic [N-1:0] expg_q[$];
    int           checks = 0;
    int           errors = 0;
    int           n_exp  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int p, input logic [W-1:0] d, input logic l);
        pq[p].push_back('{d: d, l: l});
    endtask

    task automatic expect_wr(input logic [W-1:0] d);
        exp_q.push_back(d);
        n_exp++;
    endtask

    task automatic at_post();
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += pq[k].size();
        return s;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pending() != 0 || exp_q.size() != 0 || bus.o_grant != '0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout pending=%0d exp_left=%0d", name, pending(), exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Producer model: present queue heads on negedge, retire handshaken beats at posedge
    initial begin
        logic [N-1:0]   v, l, hs;
        logic [N*W-1:0] d;
        forever begin
            @(negedge clk);
            v = '0;
            l = '0;
            d = '0;
            for (int k = 0; k < N; k++) begin
                if (pq[k].size() != 0) begin
                    v[k]          = 1'b1;
                    l[k]          = pq[k][0].l;
                    d[k*W +: W]   = pq[k][0].d;
                end
            end
            bus.i_req_valid = v;
            bus.i_req_last  = l;
            bus.i_req_data  = d;
            #4;
            if (rstn)
                chk("ready_rule", W'(bus.o_req_ready), W'(bus.o_grant & {N{~bus.i_fifo_alm_full}}));
            hs = v & bus.o_req_ready;
            @(posedge clk);
            for (int k = 0; k < N; k++)
                if (hs[k] && pq[k].size() != 0) void'(pq[k].pop_front());
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.o_fifo_wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got=%0h want=none", bus.o_fifo_wrdata);
                end else begin
                    chk("wrdata", bus.o_fifo_wrdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N-1:0] prev = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = '0;
            end else begin
                if (bus.o_grant != prev && bus.o_grant != '0) begin
                    if (prev != '0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant_no_idle got=%0b want=0000 between grants", prev);
                    end
                    if (expg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant got=%0b want=none", bus.o_grant);
                    end else begin
                        chk("grant_order", W'(bus.o_grant), W'(expg_q.pop_front()));
                    end
                end
                prev = bus.o_grant;
            end
        end
    end

    initial begin
        bus.i_req_valid     = '0;
        bus.i_req_last      = '0;
        bus.i_req_data      = '0;
        bus.i_fifo_alm_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", W'(bus.o_grant), 0);
        chk("rst_busy", W'(bus.o_busy), 0);
        chk("rst_wren", W'(bus.o_fifo_wren), 0);
        chk("rst_wrdata", bus.o_fifo_wrdata, 0);
        chk("rst_count", W'(bus.o_wr_count), 0);
        chk("rst_ready", W'(bus.o_req_ready), 0);
        rstn = 1'b1;

        // Contention: one-beat packets from everyone, producer 0 twice
        at_post();
        for (int k = 0; k < N; k++) load(k, W'(32'h10 + k), 1'b1);
        load(0, W'(32'h20), 1'b1);
        for (int k = 0; k < N; k++) expect_wr(W'(32'h10 + k));
        expect_wr(W'(32'h20));
        expg_q.push_back(4'b0001); expg_q.push_back(4'b0010); expg_q.push_back(4'b0100);
        expg_q.push_back(4'b1000); expg_q.push_back(4'b0001);
        wait_drain("rotation");
        chk("rotation_count", W'(bus.o_wr_count), W'(n_exp));

        // Single three-beat packet from producer 1
        at_post();
        load(1, W'(32'hA), 1'b0); load(1, W'(32'hB), 1'b0); load(1, W'(32'hC), 1'b1);
        expect_wr(W'(32'hA)); expect_wr(W'(32'hB)); expect_wr(W'(32'hC));
        expg_q.push_back(4'b0010);
        @(negedge clk);
        @(negedge clk);
        chk("single_grant_lat", W'(bus.o_grant), W'(4'b0010));
        chk("single_busy", W'(bus.o_busy), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_wren", W'(bus.o_fifo_wren), 1);
        end
        @(negedge clk);
        chk("single_release", W'(bus.o_grant), 0);
        chk("single_wren_off", W'(bus.o_fifo_wren), 0);
        wait_drain("single");
        chk("single_count", W'(bus.o_wr_count), W'(n_exp));

        // Burst limit: producer 2 streams 10 beats, producer 0 competes
        at_post();
        for (int i = 0; i < 10; i++) load(2, W'(32'h30 + i), 1'b0);
        load(0, W'(32'h40), 1'b1);
        for (int i = 0; i < 4; i++) expect_wr(W'(32'h30 + i));
        expect_wr(W'(32'h40));
        for (int i = 4; i < 10; i++) expect_wr(W'(32'h30 + i));
        expg_q.push_back(4'b0100); expg_q.push_back(4'b0001);
        expg_q.push_back(4'b0100); expg_q.push_back(4'b0100);
        wait_drain("burst");
        chk("burst_count", W'(bus.o_wr_count), W'(n_exp));

        // Almost-full stall for five cycles after two beats of producer 3
        at_post();
        for (int i = 0; i < 6; i++) load(3, W'(32'h50 + i), i == 5);
        for (int i = 0; i < 6; i++) expect_wr(W'(32'h50 + i));
        expg_q.push_back(4'b1000); expg_q.push_back(4'b1000);
        repeat (4) @(negedge clk);
        bus.i_fifo_alm_full = 1'b1;
        #1;
        chk("stall_ready", W'(bus.o_req_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wren", W'(bus.o_fifo_wren), 0);
            chk("stall_grant", W'(bus.o_grant), W'(4'b1000));
        end
        bus.i_fifo_alm_full = 1'b0;
        wait_drain("stall");
        chk("stall_count", W'(bus.o_wr_count), W'(n_exp));

        // Reset during the second beat of a burst
        at_post();
        load(1, W'(32'h60), 1'b0); load(1, W'(32'h61), 1'b0); load(1, W'(32'h62), 1'b1);
        expect_wr(W'(32'h60));
        expg_q.push_back(4'b0010);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_grant", W'(bus.o_grant), 0);
        chk("arst_wren", W'(bus.o_fifo_wren), 0);
        chk("arst_busy", W'(bus.o_busy), 0);
        chk("arst_count", W'(bus.o_wr_count), 0);
        chk("arst_wrdata", bus.o_fifo_wrdata, 0);
        chk("arst_ready", W'(bus.o_req_ready), 0);
        n_exp = 0;
        for (int k = 0; k < N; k++) pq[k].delete();
        for (int k = 0; k < N; k++) load(k, W'(32'h70 + k), 1'b1);
        for (int k = 0; k < N; k++) expect_wr(W'(32'h70 + k));
        expg_q.push_back(4'b0001); expg_q.push_back(4'b0010);
        expg_q.push_back(4'b0100); expg_q.push_back(4'b1000);
        @(negedge clk);
        rstn = 1'b1;
        wait_drain("reset");
        chk("reset_count", W'(bus.o_wr_count), W'(n_exp));

        // Idle release: producer 0 runs dry without last
        at_post();
        load(0, W'(32'h80), 1'b0); load(0, W'(32'h81), 1'b0);
        expect_wr(W'(32'h80)); expect_wr(W'(32'h81));
        expg_q.push_back(4'b0001);
        repeat (4) @(negedge clk);
        chk("idle_grant_held", W'(bus.o_grant), W'(4'b0001));
        chk("idle_last_wren", W'(bus.o_fifo_wren), 1);
        @(negedge clk);
        chk("idle_release", W'(bus.o_grant), 0);
        chk("idle_no_wren", W'(bus.o_fifo_wren), 0);
        chk("idle_busy", W'(bus.o_busy), 0);
        wait_drain("idle");
        chk("idle_count", W'(bus.o_wr_count), W'(n_exp));

        chk("writes_left", W'(exp_q.size()), 0);
        chk("grants_left", W'(expg_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
